// File: rtl/wb_pkg.sv
// Shared encodings for the MEM/WB writeback stage: regfile write codes,
// result-source select values and load funct3 values.
// Latency: n/a (constants only). Backpressure: n/a.
package wb_pkg;

  // Regfile write-port codes driven on WE3
  localparam logic [2:0] WE_NONE = 3'b000;
  localparam logic [2:0] WE_WORD = 3'b001;
  localparam logic [2:0] WE_LH   = 3'b010;
  localparam logic [2:0] WE_LB   = 3'b011;
  localparam logic [2:0] WE_LHU  = 3'b110;
  localparam logic [2:0] WE_LBU  = 3'b111;

  // Writeback source select; 2'b11 is reserved and never writes
  typedef enum logic [1:0] {
    RS_ALU = 2'b00,
    RS_MEM = 2'b01,
    RS_PC4 = 2'b10
  } result_src_e;

  // Load funct3 encodings
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

endpackage

// File: rtl/wb_stage_load_align.sv
// Load alignment: picks the addressed byte/half out of a memory word.
// Latency: combinational. Backpressure: none (pure function of inputs).
// Ports: funct3_i/offset_i/word_i in; data_o (target field in low bits,
//        upper bits 0), we_o (regfile code), ext_o (sign/zero extended),
//        misalign_o (offset illegal for this access size).
module load_align
  import wb_pkg::*;
(
  input  logic [2:0]  funct3_i,
  input  logic [1:0]  offset_i,
  input  logic [31:0] word_i,
  output logic [31:0] data_o,
  output logic [2:0]  we_o,
  output logic [31:0] ext_o,
  output logic        misalign_o
);

  logic [15:0] half_sel;
  logic [7:0]  byte_sel;

  // Only offset[1] matters for halves; offset[0] set means misaligned
  assign half_sel = offset_i[1] ? word_i[31:16] : word_i[15:0];

  always_comb begin
    byte_sel = word_i[7:0];
    case (offset_i)
      2'b00: byte_sel = word_i[7:0];
      2'b01: byte_sel = word_i[15:8];
      2'b10: byte_sel = word_i[23:16];
      2'b11: byte_sel = word_i[31:24];
      default: byte_sel = word_i[7:0];
    endcase
  end

  always_comb begin
    data_o     = '0;
    we_o       = WE_NONE;
    ext_o      = '0;
    misalign_o = 1'b0;
    case (funct3_i)
      F3_LW: begin
        data_o     = word_i;
        ext_o      = word_i;
        misalign_o = (offset_i != 2'b00);
        we_o       = misalign_o ? WE_NONE : WE_WORD;
      end
      F3_LH, F3_LHU: begin
        data_o     = {16'h0000, half_sel};
        ext_o      = (funct3_i == F3_LH) ? {{16{half_sel[15]}}, half_sel}
                                         : {16'h0000, half_sel};
        misalign_o = offset_i[0];
        if (!misalign_o) we_o = (funct3_i == F3_LH) ? WE_LH : WE_LHU;
      end
      F3_LB, F3_LBU: begin
        data_o = {24'h000000, byte_sel};
        ext_o  = (funct3_i == F3_LB) ? {{24{byte_sel[7]}}, byte_sel}
                                     : {24'h000000, byte_sel};
        we_o   = (funct3_i == F3_LB) ? WE_LB : WE_LBU;
      end
      default: ; // unknown load type: no write, not flagged as misaligned
    endcase
  end

endmodule

// File: rtl/wb_stage.sv
// MEM/WB pipeline register + writeback select, forwarding value, instret.
// Latency: 1 cycle (captured at posedge N, drives regfile during N+1).
// Backpressure: stall_i holds all stage state; flush_i inserts a bubble and wins over stall.
// Ports: clk/rst (sync, active high); stall_i/flush_i control; MEM-stage
//        inputs *_i; WE3/WD3/A3 regfile write port; fwd_* for hazard unit;
//        misalign_o sticky dropped-load flag; instret_o retired count.
module wb_stage
  import wb_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  stall_i,
  input  logic                  flush_i,
  input  logic                  valid_i,
  input  logic                  reg_write_i,
  input  logic [4:0]            rd_i,
  input  logic [1:0]            result_src_i,
  input  logic [2:0]            funct3_i,
  input  logic [DATA_WIDTH-1:0] alu_result_i,
  input  logic [DATA_WIDTH-1:0] read_data_i,
  input  logic [DATA_WIDTH-1:0] pc_plus4_i,
  output logic [2:0]            WE3,
  output logic [DATA_WIDTH-1:0] WD3,
  output logic [4:0]            A3,
  output logic                  fwd_valid_o,
  output logic [4:0]            fwd_rd_o,
  output logic [DATA_WIDTH-1:0] fwd_data_o,
  output logic                  misalign_o,
  output logic [CNT_WIDTH-1:0]  instret_o
);

  logic                  valid_q, valid_d;
  logic                  reg_write_q, reg_write_d;
  logic [4:0]            rd_q, rd_d;
  logic [1:0]            result_src_q, result_src_d;
  logic [2:0]            funct3_q, funct3_d;
  logic [DATA_WIDTH-1:0] alu_result_q, alu_result_d;
  logic [DATA_WIDTH-1:0] read_data_q, read_data_d;
  logic [DATA_WIDTH-1:0] pc_plus4_q, pc_plus4_d;
  logic                  misalign_q, misalign_d;
  logic [CNT_WIDTH-1:0]  instret_q, instret_d;

  logic [31:0] la_data;
  logic [2:0]  la_we;
  logic [31:0] la_ext;
  logic        la_mis;

  logic [2:0]            sel_we;
  logic [DATA_WIDTH-1:0] sel_data;
  logic [DATA_WIDTH-1:0] sel_ext;
  logic                  cur_mis;
  logic                  write_ok;

  load_align u_load_align (
    .funct3_i  (funct3_q),
    .offset_i  (alu_result_q[1:0]),
    .word_i    (read_data_q),
    .data_o    (la_data),
    .we_o      (la_we),
    .ext_o     (la_ext),
    .misalign_o(la_mis)
  );

  // Writeback source select, from stage registers only
  always_comb begin
    sel_we   = WE_NONE;
    sel_data = alu_result_q;
    sel_ext  = alu_result_q;
    case (result_src_q)
      RS_ALU: begin
        sel_we   = WE_WORD;
        sel_data = alu_result_q;
        sel_ext  = alu_result_q;
      end
      RS_PC4: begin
        sel_we   = WE_WORD;
        sel_data = pc_plus4_q;
        sel_ext  = pc_plus4_q;
      end
      RS_MEM: begin
        sel_we   = la_we;
        sel_data = la_data;
        sel_ext  = la_ext;
      end
      default: sel_we = WE_NONE; // reserved source never writes
    endcase
  end

  // A misaligned load is only "dropped" if it was a real writing load
  assign cur_mis  = valid_q && reg_write_q && (result_src_q == RS_MEM) && la_mis;
  assign write_ok = valid_q && reg_write_q && (rd_q != 5'd0) && (sel_we != WE_NONE);

  assign WE3         = write_ok ? sel_we : WE_NONE;
  assign WD3         = sel_data;
  assign A3          = rd_q;
  assign fwd_valid_o = write_ok;
  assign fwd_rd_o    = rd_q;
  assign fwd_data_o  = sel_ext;
  // Include the current drop so the flag is visible in the same cycle
  assign misalign_o  = misalign_q || cur_mis;
  assign instret_o   = instret_q;

  // Next-state: flush > stall > load (reset handled in the flop block)
  always_comb begin
    valid_d      = valid_q;
    reg_write_d  = reg_write_q;
    rd_d         = rd_q;
    result_src_d = result_src_q;
    funct3_d     = funct3_q;
    alu_result_d = alu_result_q;
    read_data_d  = read_data_q;
    pc_plus4_d   = pc_plus4_q;
    misalign_d   = misalign_q || cur_mis;
    instret_d    = instret_q;
    if (flush_i) begin
      valid_d      = 1'b0;
      reg_write_d  = 1'b0;
      rd_d         = '0;
      result_src_d = '0;
      funct3_d     = '0;
      alu_result_d = '0;
      read_data_d  = '0;
      pc_plus4_d   = '0;
    end else if (!stall_i) begin
      valid_d      = valid_i;
      reg_write_d  = reg_write_i;
      rd_d         = rd_i;
      result_src_d = result_src_i;
      funct3_d     = funct3_i;
      alu_result_d = alu_result_i;
      read_data_d  = read_data_i;
      pc_plus4_d   = pc_plus4_i;
      // Counted at the capturing edge, so a held (stalled) cycle never recounts
      if (valid_i) instret_d = instret_q + CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q      <= 1'b0;
      reg_write_q  <= 1'b0;
      rd_q         <= '0;
      result_src_q <= '0;
      funct3_q     <= '0;
      alu_result_q <= '0;
      read_data_q  <= '0;
      pc_plus4_q   <= '0;
      misalign_q   <= 1'b0;
      instret_q    <= '0;
    end else begin
      valid_q      <= valid_d;
      reg_write_q  <= reg_write_d;
      rd_q         <= rd_d;
      result_src_q <= result_src_d;
      funct3_q     <= funct3_d;
      alu_result_q <= alu_result_d;
      read_data_q  <= read_data_d;
      pc_plus4_q   <= pc_plus4_d;
      misalign_q   <= misalign_d;
      instret_q    <= instret_d;
    end
  end

endmodule

// File: tb/tb_wb_stage.sv
// Directed bench for wb_stage: each scenario task drives one or more
// instructions and compares outputs one step later against hand values.
module tb_wb_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall_i, flush_i, valid_i, reg_write_i;
  logic [4:0]  rd_i;
  logic [1:0]  result_src_i;
  logic [2:0]  funct3_i;
  logic [31:0] alu_result_i, read_data_i, pc_plus4_i;
  logic [2:0]  WE3;
  logic [31:0] WD3;
  logic [4:0]  A3;
  logic        fwd_valid_o;
  logic [4:0]  fwd_rd_o;
  logic [31:0] fwd_data_o;
  logic        misalign_o;
  logic [31:0] instret_o;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  wb_stage #(.DATA_WIDTH(32), .CNT_WIDTH(32)) dut (
    .clk(clk), .rst(rst), .stall_i(stall_i), .flush_i(flush_i),
    .valid_i(valid_i), .reg_write_i(reg_write_i), .rd_i(rd_i),
    .result_src_i(result_src_i), .funct3_i(funct3_i),
    .alu_result_i(alu_result_i), .read_data_i(read_data_i),
    .pc_plus4_i(pc_plus4_i), .WE3(WE3), .WD3(WD3), .A3(A3),
    .fwd_valid_o(fwd_valid_o), .fwd_rd_o(fwd_rd_o), .fwd_data_o(fwd_data_o),
    .misalign_o(misalign_o), .instret_o(instret_o)
  );

  task automatic drive(input logic v, input logic rw, input logic [4:0] rd,
                       input logic [1:0] src, input logic [2:0] f3,
                       input logic [31:0] alu, input logic [31:0] rdata,
                       input logic [31:0] pc);
    valid_i = v; reg_write_i = rw; rd_i = rd; result_src_i = src;
    funct3_i = f3; alu_result_i = alu; read_data_i = rdata; pc_plus4_i = pc;
  endtask

  // Advance one clock and settle outputs away from the edge
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1; stall_i = 1'b1; flush_i = 1'b0;
    drive(1'b1, 1'b1, 5'd3, 2'b00, 3'b010, 32'hDEAD_BEEF, 32'h1111_1111, 32'h44);
    tick; tick;
    vectors++; if (WE3 !== 3'b000) begin miscompares++; $display("FAIL reset_we3 got %b want 000", WE3); end
    vectors++; if (WD3 !== 32'h0) begin miscompares++; $display("FAIL reset_wd3 got %h want 0", WD3); end
    vectors++; if (A3 !== 5'd0) begin miscompares++; $display("FAIL reset_a3 got %0d want 0", A3); end
    vectors++; if (fwd_valid_o !== 1'b0) begin miscompares++; $display("FAIL reset_fwd_valid got %b want 0", fwd_valid_o); end
    vectors++; if (fwd_rd_o !== 5'd0) begin miscompares++; $display("FAIL reset_fwd_rd got %0d want 0", fwd_rd_o); end
    vectors++; if (fwd_data_o !== 32'h0) begin miscompares++; $display("FAIL reset_fwd_data got %h want 0", fwd_data_o); end
    vectors++; if (misalign_o !== 1'b0) begin miscompares++; $display("FAIL reset_misalign got %b want 0", misalign_o); end
    vectors++; if (instret_o !== 32'd0) begin miscompares++; $display("FAIL reset_instret got %0d want 0", instret_o); end
    rst = 1'b0; stall_i = 1'b0;
  endtask

  task automatic test_alu_pc4;
    drive(1'b1, 1'b1, 5'd5, 2'b00, 3'b000, 32'h0000_1234, 32'hFFFF_FFFF, 32'h0000_0040);
    tick;
    vectors++; if (WE3 !== 3'b001) begin miscompares++; $display("FAIL alu_we3 got %b want 001", WE3); end
    vectors++; if (A3 !== 5'd5) begin miscompares++; $display("FAIL alu_a3 got %0d want 5", A3); end
    vectors++; if (WD3 !== 32'h0000_1234) begin miscompares++; $display("FAIL alu_wd3 got %h want 00001234", WD3); end
    vectors++; if (fwd_valid_o !== 1'b1) begin miscompares++; $display("FAIL alu_fwd_valid got %b want 1", fwd_valid_o); end
    vectors++; if (fwd_data_o !== 32'h0000_1234) begin miscompares++; $display("FAIL alu_fwd_data got %h want 00001234", fwd_data_o); end
    vectors++; if (instret_o !== 32'd1) begin miscompares++; $display("FAIL alu_instret got %0d want 1", instret_o); end
    drive(1'b1, 1'b1, 5'd7, 2'b10, 3'b000, 32'h0000_0001, 32'h0, 32'h0000_0088);
    tick;
    vectors++; if (WE3 !== 3'b001) begin miscompares++; $display("FAIL pc4_we3 got %b want 001", WE3); end
    vectors++; if (WD3 !== 32'h0000_0088) begin miscompares++; $display("FAIL pc4_wd3 got %h want 00000088", WD3); end
    vectors++; if (fwd_rd_o !== 5'd7) begin miscompares++; $display("FAIL pc4_fwd_rd got %0d want 7", fwd_rd_o); end
    vectors++; if (instret_o !== 32'd2) begin miscompares++; $display("FAIL pc4_instret got %0d want 2", instret_o); end
  endtask

  task automatic test_byte_loads;
    // lb offset 3 of 0x80AABBCC -> 0x80, sign-extended
    drive(1'b1, 1'b1, 5'd9, 2'b01, 3'b000, 32'h0000_0103, 32'h80AA_BBCC, 32'h0);
    tick;
    vectors++; if (WE3 !== 3'b011) begin miscompares++; $display("FAIL lb_we3 got %b want 011", WE3); end
    vectors++; if (WD3[7:0] !== 8'h80) begin miscompares++; $display("FAIL lb_wd3 got %h want 80", WD3[7:0]); end
    vectors++; if (fwd_data_o !== 32'hFFFF_FF80) begin miscompares++; $display("FAIL lb_fwd_data got %h want ffffff80", fwd_data_o); end
    // lbu offset 1 -> 0xBB, zero-extended
    drive(1'b1, 1'b1, 5'd9, 2'b01, 3'b100, 32'h0000_0101, 32'h80AA_BBCC, 32'h0);
    tick;
    vectors++; if (WE3 !== 3'b111) begin miscompares++; $display("FAIL lbu_we3 got %b want 111", WE3); end
    vectors++; if (WD3 !== 32'h0000_00BB) begin miscompares++; $display("FAIL lbu_wd3 got %h want 000000bb", WD3); end
    vectors++; if (fwd_data_o !== 32'h0000_00BB) begin miscompares++; $display("FAIL lbu_fwd_data got %h want 000000bb", fwd_data_o); end
    vectors++; if (instret_o !== 32'd4) begin miscompares++; $display("FAIL lbu_instret got %0d want 4", instret_o); end
  endtask

  task automatic test_half_loads;
    drive(1'b1, 1'b1, 5'd10, 2'b01, 3'b101, 32'h0000_0102, 32'hBEEF_1234, 32'h0);
    tick;
    vectors++; if (WE3 !== 3'b110) begin miscompares++; $display("FAIL lhu_we3 got %b want 110", WE3); end
    vectors++; if (WD3 !== 32'h0000_BEEF) begin miscompares++; $display("FAIL lhu_wd3 got %h want 0000beef", WD3); end
    vectors++; if (fwd_data_o !== 32'h0000_BEEF) begin miscompares++; $display("FAIL lhu_fwd_data got %h want 0000beef", fwd_data_o); end
    drive(1'b1, 1'b1, 5'd10, 2'b01, 3'b001, 32'h0000_0102, 32'hBEEF_1234, 32'h0);
    tick;
    vectors++; if (WE3 !== 3'b010) begin miscompares++; $display("FAIL lh_we3 got %b want 010", WE3); end
    vectors++; if (fwd_data_o !== 32'hFFFF_BEEF) begin miscompares++; $display("FAIL lh_fwd_data got %h want ffffbeef", fwd_data_o); end
    drive(1'b1, 1'b1, 5'd10, 2'b01, 3'b001, 32'h0000_0100, 32'hBEEF_1234, 32'h0);
    tick;
    vectors++; if (WD3 !== 32'h0000_1234) begin miscompares++; $display("FAIL lh0_wd3 got %h want 00001234", WD3); end
    vectors++; if (instret_o !== 32'd7) begin miscompares++; $display("FAIL lh_instret got %0d want 7", instret_o); end
  endtask

  task automatic test_no_write_cases;
    // reserved result source
    drive(1'b1, 1'b1, 5'd12, 2'b11, 3'b010, 32'h0000_0010, 32'h0, 32'h0);
    tick;
    vectors++; if (WE3 !== 3'b000) begin miscompares++; $display("FAIL rsv_we3 got %b want 000", WE3); end
    vectors++; if (fwd_valid_o !== 1'b0) begin miscompares++; $display("FAIL rsv_fwd_valid got %b want 0", fwd_valid_o); end
    // undefined load funct3: no write, not misaligned
    drive(1'b1, 1'b1, 5'd12, 2'b01, 3'b011, 32'h0000_0001, 32'h1234_5678, 32'h0);
    tick;
    vectors++; if (WE3 !== 3'b000) begin miscompares++; $display("FAIL badf3_we3 got %b want 000", WE3); end
    vectors++; if (misalign_o !== 1'b0) begin miscompares++; $display("FAIL badf3_misalign got %b want 0", misalign_o); end
    vectors++; if (instret_o !== 32'd9) begin miscompares++; $display("FAIL badf3_instret got %0d want 9", instret_o); end
  endtask

  task automatic test_misalign;
    drive(1'b1, 1'b1, 5'd11, 2'b01, 3'b001, 32'h0000_0101, 32'hBEEF_1234, 32'h0);
    tick;
    vectors++; if (WE3 !== 3'b000) begin miscompares++; $display("FAIL mis_we3 got %b want 000", WE3); end
    vectors++; if (misalign_o !== 1'b1) begin miscompares++; $display("FAIL mis_flag got %b want 1", misalign_o); end
    vectors++; if (instret_o !== 32'd10) begin miscompares++; $display("FAIL mis_instret got %0d want 10", instret_o); end
    drive(1'b1, 1'b1, 5'd11, 2'b01, 3'b010, 32'h0000_0200, 32'hCAFE_F00D, 32'h0);
    tick;
    vectors++; if (WE3 !== 3'b001) begin miscompares++; $display("FAIL lw_we3 got %b want 001", WE3); end
    vectors++; if (WD3 !== 32'hCAFE_F00D) begin miscompares++; $display("FAIL lw_wd3 got %h want cafef00d", WD3); end
    vectors++; if (misalign_o !== 1'b1) begin miscompares++; $display("FAIL mis_sticky got %b want 1", misalign_o); end
    vectors++; if (instret_o !== 32'd11) begin miscompares++; $display("FAIL lw_instret got %0d want 11", instret_o); end
  endtask

  task automatic test_stall;
    drive(1'b1, 1'b1, 5'd0, 2'b00, 3'b000, 32'h0000_0055, 32'h0, 32'h0);
    tick;
    vectors++; if (WE3 !== 3'b000) begin miscompares++; $display("FAIL rd0_we3 got %b want 000", WE3); end
    vectors++; if (instret_o !== 32'd12) begin miscompares++; $display("FAIL rd0_instret got %0d want 12", instret_o); end
    stall_i = 1'b1;
    drive(1'b1, 1'b1, 5'd3, 2'b00, 3'b000, 32'h0000_0077, 32'h0, 32'h0);
    for (int i = 0; i < 2; i++) begin
      tick;
      vectors++; if (WE3 !== 3'b000) begin miscompares++; $display("FAIL stall_we3[%0d] got %b want 000", i, WE3); end
      vectors++; if (WD3 !== 32'h0000_0055) begin miscompares++; $display("FAIL stall_wd3[%0d] got %h want 00000055", i, WD3); end
      vectors++; if (A3 !== 5'd0) begin miscompares++; $display("FAIL stall_a3[%0d] got %0d want 0", i, A3); end
      vectors++; if (instret_o !== 32'd12) begin miscompares++; $display("FAIL stall_instret[%0d] got %0d want 12", i, instret_o); end
    end
    stall_i = 1'b0;
    drive(1'b0, 1'b0, 5'd0, 2'b00, 3'b000, 32'h0, 32'h0, 32'h0);
    tick;
    vectors++; if (instret_o !== 32'd12) begin miscompares++; $display("FAIL bubble_instret got %0d want 12", instret_o); end
  endtask

  task automatic test_flush_and_reset;
    flush_i = 1'b1; stall_i = 1'b1;
    drive(1'b1, 1'b1, 5'd4, 2'b00, 3'b000, 32'h0000_0099, 32'h0, 32'h0);
    tick;
    vectors++; if (WE3 !== 3'b000) begin miscompares++; $display("FAIL flush_we3 got %b want 000", WE3); end
    vectors++; if (fwd_valid_o !== 1'b0) begin miscompares++; $display("FAIL flush_fwd_valid got %b want 0", fwd_valid_o); end
    vectors++; if (instret_o !== 32'd12) begin miscompares++; $display("FAIL flush_instret got %0d want 12", instret_o); end
    flush_i = 1'b0; stall_i = 1'b0;
    drive(1'b1, 1'b1, 5'd6, 2'b00, 3'b000, 32'h0000_0066, 32'h0, 32'h0);
    tick;
    vectors++; if (WE3 !== 3'b001) begin miscompares++; $display("FAIL postflush_we3 got %b want 001", WE3); end
    vectors++; if (instret_o !== 32'd13) begin miscompares++; $display("FAIL postflush_instret got %0d want 13", instret_o); end
    rst = 1'b1;
    drive(1'b1, 1'b1, 5'd8, 2'b00, 3'b000, 32'h0000_0088, 32'h0, 32'h0);
    tick;
    vectors++; if (WE3 !== 3'b000) begin miscompares++; $display("FAIL midrst_we3 got %b want 000", WE3); end
    vectors++; if (WD3 !== 32'h0) begin miscompares++; $display("FAIL midrst_wd3 got %h want 0", WD3); end
    vectors++; if (A3 !== 5'd0) begin miscompares++; $display("FAIL midrst_a3 got %0d want 0", A3); end
    vectors++; if (misalign_o !== 1'b0) begin miscompares++; $display("FAIL midrst_misalign got %b want 0", misalign_o); end
    vectors++; if (instret_o !== 32'd0) begin miscompares++; $display("FAIL midrst_instret got %0d want 0", instret_o); end
    rst = 1'b0;
    drive(1'b0, 1'b0, 5'd0, 2'b00, 3'b000, 32'h0, 32'h0, 32'h0);
    tick;
    vectors++; if (instret_o !== 32'd0) begin miscompares++; $display("FAIL idle_instret got %0d want 0", instret_o); end
  endtask

  initial begin
    rst = 1'b1; stall_i = 1'b0; flush_i = 1'b0;
    drive(1'b0, 1'b0, 5'd0, 2'b00, 3'b000, 32'h0, 32'h0, 32'h0);
    test_reset;
    test_alu_pc4;
    test_byte_loads;
    test_half_loads;
    test_no_write_cases;
    test_misalign;
    test_stall;
    test_flush_and_reset;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
